regf_wr_arbiter: RTL and testbench

REGF_WR_ARBITER -- requirements
Module: regf_wr_arbiter

---
 rtl/regf_arb_pkg.sv | 20 ++
 rtl/regf_scoreboard.sv | 54 +++++
 rtl/regf_wr_arbiter.sv | 169 ++++++++++++++++
 tb/tb_regf_wr_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/regf_arb_pkg.sv
// Purpose : shared constants and FSM state type for the register-file write arbiter.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: NREG/AW/DW register-file geometry, default starvation limit,
//           arbiter FSM state enum.
package regf_arb_pkg;

   localparam int NREG           = 32;
   localparam int AW             = 5;
   localparam int DW             = 32;
   localparam int STARVE_MAX_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FORCE = 2'd2
   } arb_state_e;

endpackage

// File: rtl/regf_scoreboard.sv
// Purpose : pending-destination bitmap with two combinational busy lookups.
// Latency : set/clear visible on busy_* one cycle after the update is presented.
// Backpressure: none; accepts one set and one clear every cycle.
//
// Ports: clk/rst (sync, active-high); set_vld/set_idx mark a destination
//        pending; clr_vld/clr_idx retire one; ra/rb lookup -> busy_a/busy_b.
module regf_scoreboard
   import regf_arb_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          set_vld,
   input  logic [AW-1:0] set_idx,
   input  logic          clr_vld,
   input  logic [AW-1:0] clr_idx,
   input  logic [AW-1:0] ra,
   input  logic [AW-1:0] rb,
   output logic          busy_a,
   output logic          busy_b
);

   logic [NREG-1:0] pending_q, pending_d;
   logic [NREG-1:0] set_mask, clr_mask;
   logic            set_eff;
   logic            reissue;

   // r0 is hard-wired zero and never becomes pending.
   assign set_eff  = set_vld && (set_idx != '0);
   assign set_mask = NREG'(set_eff) << set_idx;
   assign clr_mask = NREG'(clr_vld) << clr_idx;

   // Set is applied after clear so a same-cycle reissue keeps the bit.
   always_comb begin
      pending_d = (pending_q & ~clr_mask) | set_mask;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign busy_a = pending_q[ra] && (ra != '0);
   assign busy_b = pending_q[rb] && (rb != '0);

   // Issuing to a destination that is still pending (and not retiring this
   // same cycle) means the issue logic lost track of a hazard.
   assign reissue = set_eff && pending_q[set_idx] && !(clr_vld && (clr_idx == set_idx));

   a_no_reissue : assert property (@(posedge clk) disable iff (rst) !reissue);

endmodule

// File: rtl/regf_wr_arbiter.sv
// Purpose : arbitrates pipeline writeback vs multicycle unit onto one register-file write port.
// Latency : granted write appears on rf_* one cycle after it is presented.
// Backpressure: mu_ready low while wb wins; after STARVE_MAX lost cycles mu is forced and stall_wb asserted.
//
// Ports: clk/rst (sync, active-high); wb_we/wb_rw/wb_w pipeline writeback;
//        mu_valid/mu_ready/mu_rw/mu_w multicycle unit; iss_valid/iss_rd mark
//        a destination pending; rA/rB -> busy_a/busy_b hazard lookups;
//        stall_wb (registered); rf_we/rf_rw/rf_w registered write port.
// Optional: define REGF_WR_ARBITER_STATS_EN to add saturating conflict_cnt
//           and force_cnt outputs.
module regf_wr_arbiter
   import regf_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          wb_we,
   input  logic [AW-1:0] wb_rw,
   input  logic [DW-1:0] wb_w,
   input  logic          mu_valid,
   output logic          mu_ready,
   input  logic [AW-1:0] mu_rw,
   input  logic [DW-1:0] mu_w,
   input  logic          iss_valid,
   input  logic [AW-1:0] iss_rd,
   input  logic [AW-1:0] rA,
   input  logic [AW-1:0] rB,
   output logic          busy_a,
   output logic          busy_b,
`ifdef REGF_WR_ARBITER_STATS_EN
   output logic [15:0]   conflict_cnt,
   output logic [15:0]   force_cnt,
`endif
   output logic          rf_we,
   output logic [AW-1:0] rf_rw,
   output logic [DW-1:0] rf_w,
   output logic          stall_wb
);

   localparam int CW = $clog2(STARVE_MAX + 1);

   arb_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rf_we_q, rf_we_d;
   logic [AW-1:0] rf_rw_q, rf_rw_d;
   logic [DW-1:0] rf_w_q, rf_w_d;
   logic          stall_wb_q, stall_wb_d;

   logic in_force;
   logic mu_hs;
   logic mu_lost;
   logic wb_gnt;

   assign in_force = (state_q == ST_FORCE);

   // In FORCE the pipeline request is ignored; the pipeline re-presents it.
   assign mu_ready = mu_valid && !rst && (!wb_we || in_force);
   assign mu_hs    = mu_valid && mu_ready;
   assign mu_lost  = mu_valid && !mu_ready && !rst;
   assign wb_gnt   = wb_we && !in_force && !rst;

   // Starvation counter and FSM next state. The counter is compared on its
   // next value so exactly STARVE_MAX cycles are lost before FORCE.
   always_comb begin
      cnt_d   = cnt_q;
      state_d = state_q;
      if (mu_hs) begin
         cnt_d = '0;
      end else if (mu_lost && (cnt_q != CW'(STARVE_MAX))) begin
         cnt_d = cnt_q + CW'(1);
      end
      case (state_q)
         ST_IDLE: begin
            if (mu_lost) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mu_hs)                           state_d = ST_IDLE;
            else if (cnt_d == CW'(STARVE_MAX))   state_d = ST_FORCE;
         end
         ST_FORCE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      stall_wb_d = (state_d == ST_FORCE);
   end

   // Write-port mux. Address/data hold when idle; writes to r0 are
   // suppressed but the mu handshake still completes.
   always_comb begin
      rf_we_d = 1'b0;
      rf_rw_d = rf_rw_q;
      rf_w_d  = rf_w_q;
      if (wb_gnt) begin
         rf_we_d = (wb_rw != '0);
         rf_rw_d = wb_rw;
         rf_w_d  = wb_w;
      end else if (mu_hs) begin
         rf_we_d = (mu_rw != '0);
         rf_rw_d = mu_rw;
         rf_w_d  = mu_w;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         rf_we_q    <= 1'b0;
         rf_rw_q    <= '0;
         rf_w_q     <= '0;
         stall_wb_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rf_we_q    <= rf_we_d;
         rf_rw_q    <= rf_rw_d;
         rf_w_q     <= rf_w_d;
         stall_wb_q <= stall_wb_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_rw    = rf_rw_q;
   assign rf_w     = rf_w_q;
   assign stall_wb = stall_wb_q;

   regf_scoreboard u_sb (
      .clk     (clk),
      .rst     (rst),
      .set_vld (iss_valid),
      .set_idx (iss_rd),
      .clr_vld (mu_hs),
      .clr_idx (mu_rw),
      .ra      (rA),
      .rb      (rB),
      .busy_a  (busy_a),
      .busy_b  (busy_b)
   );

`ifdef REGF_WR_ARBITER_STATS_EN
   logic [15:0] conflict_cnt_q, conflict_cnt_d;
   logic [15:0] force_cnt_q, force_cnt_d;

   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      force_cnt_d    = force_cnt_q;
      if (mu_lost && (conflict_cnt_q != 16'hFFFF)) begin
         conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
      if ((state_d == ST_FORCE) && !in_force && (force_cnt_q != 16'hFFFF)) begin
         force_cnt_d = force_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_cnt_q <= '0;
         force_cnt_q    <= '0;
      end else begin
         conflict_cnt_q <= conflict_cnt_d;
         force_cnt_q    <= force_cnt_d;
      end
   end

   assign conflict_cnt = conflict_cnt_q;
   assign force_cnt    = force_cnt_q;
`endif

endmodule

// File: tb/tb_regf_wr_arbiter.sv
// Purpose : directed self-checking bench for regf_wr_arbiter.
// Latency : n/a.
// Backpressure: n/a.
module tb_regf_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_rw = '0;
   logic [31:0] wb_w = '0;
   logic        mu_valid = 1'b0;
   logic        mu_ready;
   logic [4:0]  mu_rw = '0;
   logic [31:0] mu_w = '0;
   logic        iss_valid = 1'b0;
   logic [4:0]  iss_rd = '0;
   logic [4:0]  rA = '0;
   logic [4:0]  rB = '0;
   logic        busy_a, busy_b;
   logic        rf_we;
   logic [4:0]  rf_rw;
   logic [31:0] rf_w;
   logic        stall_wb;
`ifdef REGF_WR_ARBITER_STATS_EN
   logic [15:0] conflict_cnt, force_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   regf_wr_arbiter #(.STARVE_MAX(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_we    (wb_we),
      .wb_rw    (wb_rw),
      .wb_w     (wb_w),
      .mu_valid (mu_valid),
      .mu_ready (mu_ready),
      .mu_rw    (mu_rw),
      .mu_w     (mu_w),
      .iss_valid(iss_valid),
      .iss_rd   (iss_rd),
      .rA       (rA),
      .rB       (rB),
      .busy_a   (busy_a),
      .busy_b   (busy_b),
`ifdef REGF_WR_ARBITER_STATS_EN
      .conflict_cnt(conflict_cnt),
      .force_cnt   (force_cnt),
`endif
      .rf_we    (rf_we),
      .rf_rw    (rf_rw),
      .rf_w     (rf_w),
      .stall_wb (stall_wb)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reads the whole pending map through the rA lookup; inputs are idle so
   // crossing clock edges during the scan does not change state.
   task automatic scan_busy(output logic [31:0] map);
      map = '0;
      for (int r = 0; r < 32; r++) begin
         rA = 5'(r);
         #1;
         map[r] = busy_a;
      end
      rA = '0;
   endtask

   initial begin
      logic [31:0] map;

      // Reset with an mu request in flight.
      rst = 1'b1; mu_valid = 1'b1; mu_rw = 5'd3; mu_w = 32'hDEAD;
      #1;
      chk("rst_mu_ready", 32'(mu_ready), 32'd0);
      tick(); tick();
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_rf_rw", 32'(rf_rw), 32'd0);
      chk("rst_rf_w", rf_w, 32'd0);
      chk("rst_stall", 32'(stall_wb), 32'd0);
      mu_valid = 1'b0; rst = 1'b0;
      tick();
      chk("rst_drop_mu", 32'(rf_we), 32'd0);
      scan_busy(map);
      chk("rst_pending", map, 32'd0);

      // Plain writeback.
      wb_we = 1'b1; wb_rw = 5'd3; wb_w = 32'h11;
      tick();
      wb_we = 1'b0;
      chk("wb_rf_we", 32'(rf_we), 32'd1);
      chk("wb_rf_rw", 32'(rf_rw), 32'd3);
      chk("wb_rf_w", rf_w, 32'h11);
      tick();
      chk("wb_idle_we", 32'(rf_we), 32'd0);

      // mu write with pending retirement.
      iss_valid = 1'b1; iss_rd = 5'd5;
      tick();
      iss_valid = 1'b0; rA = 5'd5;
      #1;
      chk("mu_busy_set", 32'(busy_a), 32'd1);
      mu_valid = 1'b1; mu_rw = 5'd5; mu_w = 32'hAA;
      #1;
      chk("mu_ready_free", 32'(mu_ready), 32'd1);
      tick();
      mu_valid = 1'b0;
      chk("mu_rf_we", 32'(rf_we), 32'd1);
      chk("mu_rf_rw", 32'(rf_rw), 32'd5);
      chk("mu_rf_w", rf_w, 32'hAA);
      #1;
      chk("mu_busy_clr", 32'(busy_a), 32'd0);

      // Starvation: wb held 6 cycles against mu; 4 lost, 1 forced, then idle.
      for (int i = 0; i < 6; i++) begin
         wb_we = 1'b1; wb_rw = 5'd1; wb_w = 32'h100 + 32'(i);
         mu_valid = (i < 5); mu_rw = 5'd9; mu_w = 32'hBB;
         #1;
         chk($sformatf("starve_ready_%0d", i), 32'(mu_ready), (i == 4) ? 32'd1 : 32'd0);
         chk($sformatf("starve_stall_%0d", i), 32'(stall_wb), (i == 4) ? 32'd1 : 32'd0);
         tick();
         chk($sformatf("starve_we_%0d", i), 32'(rf_we), 32'd1);
         chk($sformatf("starve_rw_%0d", i), 32'(rf_rw), (i == 4) ? 32'd9 : 32'd1);
         chk($sformatf("starve_w_%0d", i), rf_w, (i == 4) ? 32'hBB : (32'h100 + 32'(i)));
      end
      wb_we = 1'b0; mu_valid = 1'b0;
      tick();
      chk("starve_idle_stall", 32'(stall_wb), 32'd0);

      // Scoreboard: set, lookup on both ports, clear, set-wins collision.
      iss_valid = 1'b1; iss_rd = 5'd7;
      tick();
      iss_valid = 1'b0; rA = 5'd7; rB = 5'd7;
      #1;
      chk("sb_busy_a", 32'(busy_a), 32'd1);
      chk("sb_busy_b", 32'(busy_b), 32'd1);
      mu_valid = 1'b1; mu_rw = 5'd7; mu_w = 32'h77;
      tick();
      mu_valid = 1'b0;
      chk("sb_clear", 32'(busy_a), 32'd0);
      iss_valid = 1'b1; iss_rd = 5'd7;
      tick();
      chk("sb_reset_bit", 32'(busy_a), 32'd1);
      mu_valid = 1'b1; mu_rw = 5'd7; mu_w = 32'h78;
      tick();
      iss_valid = 1'b0;
      chk("sb_set_wins", 32'(busy_a), 32'd1);
      tick();
      mu_valid = 1'b0;
      chk("sb_clear2", 32'(busy_a), 32'd0);
      chk("sb_clear2_we", 32'(rf_we), 32'd1);

      // Destination r0: never pending, never written, handshake still done.
      iss_valid = 1'b1; iss_rd = 5'd0;
      tick();
      iss_valid = 1'b0; rA = 5'd0; rB = 5'd0;
      #1;
      chk("r0_busy_a", 32'(busy_a), 32'd0);
      mu_valid = 1'b1; mu_rw = 5'd0; mu_w = 32'h55;
      #1;
      chk("r0_mu_ready", 32'(mu_ready), 32'd1);
      tick();
      mu_valid = 1'b0;
      chk("r0_rf_we", 32'(rf_we), 32'd0);

      // Fill r1..r31 pending, enter FORCE, then reset mid-FORCE.
      for (int r = 1; r < 32; r++) begin
         iss_valid = 1'b1; iss_rd = 5'(r);
         tick();
      end
      iss_valid = 1'b0;
      scan_busy(map);
      chk("fill_pending", map, 32'hFFFF_FFFE);
      @(negedge clk);
      wb_we = 1'b1; wb_rw = 5'd2; wb_w = 32'h22;
      mu_valid = 1'b1; mu_rw = 5'd12; mu_w = 32'hCC;
      for (int i = 0; i < 4; i++) tick();
      chk("force_stall", 32'(stall_wb), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0; wb_we = 1'b0; mu_valid = 1'b0;
      chk("rstf_stall", 32'(stall_wb), 32'd0);
      chk("rstf_rf_we", 32'(rf_we), 32'd0);
      chk("rstf_rf_w", rf_w, 32'd0);
      scan_busy(map);
      chk("rstf_pending", map, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
